segment_transition_ctl: RTL and testbench
=========================================

# segment_transition_ctl

Sequences the active read segment of a two-segment double-buffered sequencer, either modulation or STM; the two instances differ only in the CYCLE width driven by the sampler. The block consumes the per-update transition request (requested segment, transition mode, transition value, per-segment repeat count) and decides the cycle on which the sampler swaps segments. It also counts completed loops and asserts STOP once the repeat budget is exhausted. It sits between the settings register block and the mod/STM sampler.

## Interface
Parameters
- none; all widths are fixed by the settings structs.

Ports
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  reset, synchronous and active-low.
- UPDATE  in  1  one-cycle strobe: a new transition request is valid this cycle.
- REQ_RD_SEGMENT  in  1  requested segment; sampled on UPDATE.
- TRANSITION_MODE  in  8  mode code; sampled on UPDATE.
- TRANSITION_VALUE  in  64  mode argument; sampled on UPDATE.
- REP0, REP1  in  16 each  repeat count per segment; 0xFFFF = infinite, else the segment plays REP+1 loops; sampled on UPDATE.
- SYS_TIME  in  64  free-running system time, same units as TRANSITION_VALUE.
- IDX_WRAP  in  1  one-cycle pulse from the sampler when its read index wraps to 0.
- GPIO_IN  in  4  asynchronous trigger pins.
- SEGMENT  out  1  active read segment.
- STOP  out  1  repeat budget exhausted; the sampler holds its last sample.
- PENDING  out  1  a request has been accepted and is not yet executed.
- SWITCHED  out  1  one-cycle pulse on the cycle SEGMENT is updated.

## Operation
Mode codes
- 0x00 SYNC_IDX: switch on the next IDX_WRAP.
- 0x01 SYS_TIME: switch when SYS_TIME >= TRANSITION_VALUE, unsigned 64-bit compare.
- 0x02 GPIO: switch on a rising edge of GPIO_IN[TRANSITION_VALUE[1:0]].
- 0xF0 EXT: switch to REQ immediately, then toggle SEGMENT at every IDX_WRAP until the next UPDATE. STOP is forced 0 while in EXT.
- 0xFF IMMEDIATE: switch on the next cycle.
- Any other code: the request is ignored and no state changes.

States: IDLE, WAIT, EXT
- IDLE + UPDATE with mode 0x00, 0x01 or 0x02 → WAIT; PENDING=1; latch segment, value and REP of the requested segment.
- IDLE or WAIT + UPDATE(0xFF) → switch, then IDLE.
- IDLE or WAIT + UPDATE(0xF0) → switch, then EXT.
- WAIT + trigger → switch, then IDLE; PENDING=0.
- WAIT + new UPDATE → the new request overwrites the pending one; the old trigger is discarded.
- EXT + any valid UPDATE → handled as from IDLE.

Switch action (one cycle)
- SEGMENT ← latched segment.
- SWITCHED=1.
- Loop counter ← 0.
- STOP ← 0.
- Effective REP ← latched REP.

A switch to the already-active segment is legal: it restarts the loop count and pulses SWITCHED.

Loop counting (IDLE only)
- Each IDX_WRAP increments a 16-bit counter.
- When effective REP ≠ 0xFFFF and the counter reaches REP+1, STOP ← 1 and stays set until the next switch.
- The counter saturates; it never wraps.

GPIO path
- Two-flop synchronizer, then a registered edge detector.

## Timing
- Reset values:
  - SEGMENT=0, STOP=0, PENDING=0, SWITCHED=0.
  - State IDLE, loop counter 0.
  - Effective REP = 0xFFFF, so STOP never asserts before the first update.
- IMMEDIATE or EXT: UPDATE at cycle N → SEGMENT and SWITCHED at N+1.
- SYNC_IDX: IDX_WRAP at cycle M (M > N) → switch at M+1.
  - An IDX_WRAP coincident with UPDATE does not trigger.
  - The triggering wrap is not counted as a loop of the new segment.
- SYS_TIME: the compare is registered. If the condition first holds at cycle M ≥ N+1, the switch happens at M+1.
  - A value already in the past switches at N+2.
- GPIO: pin edge → switch 4 cycles later (2 sync + 1 edge + 1 output).
  - Edges before N+1 are ignored.
- STOP: asserts the cycle after the IDX_WRAP that completes loop REP+1.
- Simultaneous trigger and UPDATE: the UPDATE wins and the pending trigger is dropped.
- RST_N low mid-operation: all state returns to reset values on the next edge, including a pending request.

## Test plan
- Reset, then UPDATE(0xFF, seg 1, REP1=0xFFFF) at cycle 10 → SEGMENT=1 and SWITCHED pulse at cycle 11; 100 IDX_WRAPs → STOP stays 0.
- UPDATE(0x00, seg 1, REP1=2) → PENDING=1 until the first IDX_WRAP.
  - Switch one cycle after that wrap.
  - STOP asserts one cycle after the 3rd subsequent wrap.
- UPDATE(0x01, value=SYS_TIME+1000) → switch exactly 1 cycle after SYS_TIME reaches the value.
  - Repeat with a value in the past → switch at N+2.
- UPDATE(0x02, value=2) with GPIO_IN[1] toggling and GPIO_IN[2] rising at cycle K → single switch at K+4.
- UPDATE(0xF0, seg 0) → SEGMENT alternates on every IDX_WRAP and STOP stays 0.
  - UPDATE(0xFF, seg 1) → EXT ends and SEGMENT holds 1.
- WAIT(0x00) overwritten by UPDATE(0x7A) → pending request kept.
  - Then UPDATE(0xFF), then assert RST_N=0 → all outputs return to 0 next edge.

Source files
------------

// File: rtl/segment_transition_ctl.sv
// Decides the cycle on which the sampler swaps read segments and tracks
// the loop budget of the active segment (STOP).
module segment_transition_ctl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        UPDATE,
    input  logic        REQ_RD_SEGMENT,
    input  logic [7:0]  TRANSITION_MODE,
    input  logic [63:0] TRANSITION_VALUE,
    input  logic [15:0] REP0,
    input  logic [15:0] REP1,
    input  logic [63:0] SYS_TIME,
    input  logic        IDX_WRAP,
    input  logic [3:0]  GPIO_IN,
    output logic        SEGMENT,
    output logic        STOP,
    output logic        PENDING,
    output logic        SWITCHED
);
    typedef enum logic [1:0] {IDLE, WAIT, EXT} state_t;

    localparam logic [7:0]  MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0]  MODE_SYS_TIME = 8'h01;
    localparam logic [7:0]  MODE_GPIO     = 8'h02;
    localparam logic [7:0]  MODE_EXT      = 8'hF0;
    localparam logic [7:0]  MODE_IMM      = 8'hFF;
    localparam logic [15:0] REP_INF       = 16'hFFFF;

    state_t      state, state_nxt;
    logic        segment, segment_nxt;
    logic        stop, stop_nxt;
    logic        switched, switched_nxt;
    logic        lat_seg, lat_seg_nxt;
    logic [7:0]  lat_mode, lat_mode_nxt;
    logic [63:0] lat_value, lat_value_nxt;
    logic [15:0] lat_rep, lat_rep_nxt;
    logic [15:0] eff_rep, eff_rep_nxt;
    logic [15:0] loop_cnt, loop_cnt_nxt;

    logic [3:0]  gpio_s1, gpio_s2, gpio_s3, gpio_rise;

    logic        update_ok;
    logic        is_imm, is_ext;
    logic        trigger;
    logic        do_switch;
    logic        sw_seg;
    logic [15:0] sw_rep;
    logic [15:0] req_rep;
    logic [15:0] cnt_inc;

    // Pins are asynchronous: two sync flops, then a registered rise detect
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            gpio_s1   <= '0;
            gpio_s2   <= '0;
            gpio_s3   <= '0;
            gpio_rise <= '0;
        end else begin
            gpio_s1   <= GPIO_IN;
            gpio_s2   <= gpio_s1;
            gpio_s3   <= gpio_s2;
            gpio_rise <= gpio_s2 & ~gpio_s3;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            segment   <= 1'b0;
            stop      <= 1'b0;
            switched  <= 1'b0;
            lat_seg   <= 1'b0;
            lat_mode  <= 8'h00;
            lat_value <= '0;
            lat_rep   <= REP_INF;
            eff_rep   <= REP_INF;
            loop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            segment   <= segment_nxt;
            stop      <= stop_nxt;
            switched  <= switched_nxt;
            lat_seg   <= lat_seg_nxt;
            lat_mode  <= lat_mode_nxt;
            lat_value <= lat_value_nxt;
            lat_rep   <= lat_rep_nxt;
            eff_rep   <= eff_rep_nxt;
            loop_cnt  <= loop_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        segment_nxt   = segment;
        stop_nxt      = stop;
        switched_nxt  = 1'b0;
        lat_seg_nxt   = lat_seg;
        lat_mode_nxt  = lat_mode;
        lat_value_nxt = lat_value;
        lat_rep_nxt   = lat_rep;
        eff_rep_nxt   = eff_rep;
        loop_cnt_nxt  = loop_cnt;
        do_switch     = 1'b0;
        sw_seg        = lat_seg;
        sw_rep        = lat_rep;

        req_rep = REQ_RD_SEGMENT ? REP1 : REP0;
        is_imm  = TRANSITION_MODE == MODE_IMM;
        is_ext  = TRANSITION_MODE == MODE_EXT;
        update_ok = UPDATE && (TRANSITION_MODE inside
            {MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT, MODE_IMM});
        cnt_inc = (loop_cnt == 16'hFFFF) ? loop_cnt : loop_cnt + 16'd1;

        case (lat_mode)
            MODE_SYNC_IDX: trigger = IDX_WRAP;
            MODE_SYS_TIME: trigger = SYS_TIME >= lat_value;
            MODE_GPIO:     trigger = gpio_rise[lat_value[1:0]];
            default:       trigger = 1'b0;
        endcase

        // A fresh request always beats a trigger of the pending one
        if (update_ok) begin
            unique case (1'b1)
                is_imm: begin
                    do_switch = 1'b1;
                    sw_seg    = REQ_RD_SEGMENT;
                    sw_rep    = req_rep;
                    state_nxt = IDLE;
                end
                is_ext: begin
                    do_switch = 1'b1;
                    sw_seg    = REQ_RD_SEGMENT;
                    sw_rep    = req_rep;
                    state_nxt = EXT;
                end
                default: begin
                    state_nxt     = WAIT;
                    lat_seg_nxt   = REQ_RD_SEGMENT;
                    lat_mode_nxt  = TRANSITION_MODE;
                    lat_value_nxt = TRANSITION_VALUE;
                    lat_rep_nxt   = req_rep;
                end
            endcase
        end else begin
            unique case (state)
                WAIT: begin
                    if (trigger) begin
                        do_switch = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT: begin
                    if (IDX_WRAP) begin
                        segment_nxt  = ~segment;
                        switched_nxt = 1'b1;
                    end
                end
                default: begin
                    if (IDX_WRAP) begin
                        loop_cnt_nxt = cnt_inc;
                        if (eff_rep != REP_INF &&
                            {1'b0, cnt_inc} >= {1'b0, eff_rep} + 17'd1)
                            stop_nxt = 1'b1;
                    end
                end
            endcase
        end

        if (do_switch) begin
            segment_nxt  = sw_seg;
            switched_nxt = 1'b1;
            loop_cnt_nxt = '0;
            stop_nxt     = 1'b0;
            eff_rep_nxt  = sw_rep;
        end
    end

    assign SEGMENT  = segment;
    assign STOP     = stop;
    assign PENDING  = state == WAIT;
    assign SWITCHED = switched;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Bench for segment_transition_ctl: expected switch events are queued
// when stimulus is driven and matched against SWITCHED pulses.
module tb_segment_transition_ctl;
    logic        CLK;
    logic        RST_N;
    logic        UPDATE;
    logic        REQ_RD_SEGMENT;
    logic [7:0]  TRANSITION_MODE;
    logic [63:0] TRANSITION_VALUE;
    logic [15:0] REP0;
    logic [15:0] REP1;
    logic [63:0] SYS_TIME;
    logic        IDX_WRAP;
    logic [3:0]  GPIO_IN;
    logic        SEGMENT;
    logic        STOP;
    logic        PENDING;
    logic        SWITCHED;

    typedef struct {
        int   cyc;
        logic seg;
    } sw_t;

    sw_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] time_base = 64'h8000_0000_0000_0000;

    segment_transition_ctl dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .UPDATE(UPDATE),
        .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
        .TRANSITION_MODE(TRANSITION_MODE),
        .TRANSITION_VALUE(TRANSITION_VALUE),
        .REP0(REP0),
        .REP1(REP1),
        .SYS_TIME(SYS_TIME),
        .IDX_WRAP(IDX_WRAP),
        .GPIO_IN(GPIO_IN),
        .SEGMENT(SEGMENT),
        .STOP(STOP),
        .PENDING(PENDING),
        .SWITCHED(SWITCHED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign SYS_TIME = time_base + 64'(cyc);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Inputs are driven at the negedge of the cycle they belong to
    task automatic do_update(input logic [7:0] mode, input logic seg,
                             input logic [63:0] val,
                             input logic [15:0] r0, input logic [15:0] r1);
        UPDATE           = 1'b1;
        TRANSITION_MODE  = mode;
        REQ_RD_SEGMENT   = seg;
        TRANSITION_VALUE = val;
        REP0             = r0;
        REP1             = r1;
        @(negedge CLK);
        UPDATE = 1'b0;
    endtask

    task automatic do_wrap();
        IDX_WRAP = 1'b1;
        @(negedge CLK);
        IDX_WRAP = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (SWITCHED) begin
            if (exp_q.size() == 0) begin
                check("sw_unexpected", 64'(SWITCHED), 64'd0);
            end else begin
                sw_t e;
                e = exp_q.pop_front();
                check("sw_cycle", 64'(cyc), 64'(e.cyc));
                check("sw_seg", 64'(SEGMENT), 64'(e.seg));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d",
                 cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        RST_N = 1'b0;
        UPDATE = 1'b0;
        REQ_RD_SEGMENT = 1'b0;
        TRANSITION_MODE = 8'h00;
        TRANSITION_VALUE = '0;
        REP0 = 16'hFFFF;
        REP1 = 16'hFFFF;
        IDX_WRAP = 1'b0;
        GPIO_IN = 4'h0;
        idle(3);
        check("rst_segment", 64'(SEGMENT), 64'd0);
        check("rst_stop", 64'(STOP), 64'd0);
        check("rst_pending", 64'(PENDING), 64'd0);
        check("rst_switched", 64'(SWITCHED), 64'd0);
        RST_N = 1'b1;
        while (cyc < 10) @(negedge CLK);

        // Immediate switch, infinite repeat
        n = cyc;
        exp_q.push_back('{n + 1, 1'b1});
        do_update(8'hFF, 1'b1, 64'd0, 16'hFFFF, 16'hFFFF);
        check("imm_segment", 64'(SEGMENT), 64'd1);
        for (int i = 0; i < 100; i++) begin
            do_wrap();
            idle(1);
        end
        check("inf_stop", 64'(STOP), 64'd0);

        // SYNC_IDX with REP1=2
        do_update(8'h00, 1'b1, 64'd0, 16'hFFFF, 16'd2);
        check("sync_pend", 64'(PENDING), 64'd1);
        idle(3);
        check("sync_pend_hold", 64'(PENDING), 64'd1);
        m = cyc;
        exp_q.push_back('{m + 1, 1'b1});
        do_wrap();
        check("sync_pend_clr", 64'(PENDING), 64'd0);
        do_wrap();
        idle(1);
        do_wrap();
        idle(1);
        check("rep_stop_early", 64'(STOP), 64'd0);
        do_wrap();
        check("rep_stop", 64'(STOP), 64'd1);
        idle(2);
        check("rep_stop_hold", 64'(STOP), 64'd1);

        // SYS_TIME in the future
        n = cyc;
        exp_q.push_back('{n + 1001, 1'b0});
        do_update(8'h01, 1'b0, SYS_TIME + 64'd1000, 16'hFFFF, 16'hFFFF);
        check("time_pend", 64'(PENDING), 64'd1);
        while (cyc < n + 1000) @(negedge CLK);
        check("time_pend_last", 64'(PENDING), 64'd1);
        idle(1);
        check("time_pend_clr", 64'(PENDING), 64'd0);
        check("time_segment", 64'(SEGMENT), 64'd0);
        check("time_stop_clr", 64'(STOP), 64'd0);

        // SYS_TIME already in the past
        idle(2);
        n = cyc;
        exp_q.push_back('{n + 2, 1'b1});
        do_update(8'h01, 1'b1, SYS_TIME - 64'd5, 16'hFFFF, 16'hFFFF);
        check("past_pend", 64'(PENDING), 64'd1);
        idle(1);
        check("past_segment", 64'(SEGMENT), 64'd1);

        // GPIO on pin 2 while pin 1 toggles
        idle(2);
        do_update(8'h02, 1'b0, 64'd2, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            GPIO_IN[1] = ~GPIO_IN[1];
            idle(1);
        end
        check("gpio_pend", 64'(PENDING), 64'd1);
        m = cyc;
        exp_q.push_back('{m + 4, 1'b0});
        GPIO_IN[2] = 1'b1;
        idle(3);
        check("gpio_pend_k3", 64'(PENDING), 64'd1);
        idle(1);
        check("gpio_segment", 64'(SEGMENT), 64'd0);
        for (int i = 0; i < 4; i++) begin
            GPIO_IN[1] = ~GPIO_IN[1];
            idle(1);
        end

        // EXT: toggle on every wrap, STOP held low despite REP0=0
        n = cyc;
        exp_q.push_back('{n + 1, 1'b0});
        do_update(8'hF0, 1'b0, 64'd0, 16'd0, 16'hFFFF);
        for (int k = 1; k <= 4; k++) begin
            logic s;
            s = k[0];
            m = cyc;
            exp_q.push_back('{m + 1, s});
            do_wrap();
            check("ext_segment", 64'(SEGMENT), 64'(s));
            check("ext_stop", 64'(STOP), 64'd0);
            idle(1);
        end
        n = cyc;
        exp_q.push_back('{n + 1, 1'b1});
        do_update(8'hFF, 1'b1, 64'd0, 16'hFFFF, 16'hFFFF);
        do_wrap();
        idle(1);
        do_wrap();
        check("ext_end_segment", 64'(SEGMENT), 64'd1);

        // Unknown code leaves pending request intact
        do_update(8'h00, 1'b0, 64'd0, 16'hFFFF, 16'hFFFF);
        do_update(8'h7A, 1'b1, 64'd0, 16'hFFFF, 16'hFFFF);
        check("bad_pend", 64'(PENDING), 64'd1);
        check("bad_segment", 64'(SEGMENT), 64'd1);
        m = cyc;
        exp_q.push_back('{m + 1, 1'b0});
        do_wrap();
        check("kept_segment", 64'(SEGMENT), 64'd0);

        // REP=0 stops after a single loop, then reset clears everything
        n = cyc;
        exp_q.push_back('{n + 1, 1'b1});
        do_update(8'hFF, 1'b1, 64'd0, 16'hFFFF, 16'd0);
        do_wrap();
        check("rep0_stop", 64'(STOP), 64'd1);
        do_update(8'h00, 1'b0, 64'd0, 16'hFFFF, 16'hFFFF);
        check("pre_rst_pend", 64'(PENDING), 64'd1);
        RST_N = 1'b0;
        idle(1);
        RST_N = 1'b1;
        check("mid_rst_segment", 64'(SEGMENT), 64'd0);
        check("mid_rst_stop", 64'(STOP), 64'd0);
        check("mid_rst_pending", 64'(PENDING), 64'd0);
        check("mid_rst_switched", 64'(SWITCHED), 64'd0);
        do_wrap();
        idle(1);
        do_wrap();
        idle(2);
        check("post_rst_stop", 64'(STOP), 64'd0);
        check("post_rst_segment", 64'(SEGMENT), 64'd0);

        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
